// File: rtl/npc_unit_pkg.sv
// Shared constants for the fetch-stage next-PC unit and its return-address stack.
package npc_unit_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Link registers: ra (x1) and the alternate link register t0 (x5)
  localparam logic [4:0]  LINK_X1      = 5'd1;
  localparam logic [4:0]  LINK_X5      = 5'd5;

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/npc_unit_if.sv
// Redirect, predictor, link and status signals between the fetch control and npc_unit.
interface npc_unit_if
  import npc_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            stall;
  logic            predict_valid;
  logic [XLEN-1:0] predict_target;
  logic            br;
  logic [XLEN-1:0] br_target;
  logic            jalr;
  logic [XLEN-1:0] jalr_target;
  logic            jal;
  logic [XLEN-1:0] jal_target;
  logic            link_push;
  logic            link_pop;
  logic [XLEN-1:0] link_addr;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;
  logic            redirect;
  logic [31:0]     mispredict_cnt;

  modport master (
    output stall, predict_valid, predict_target, br, br_target, jalr, jalr_target,
           jal, jal_target, link_push, link_pop, link_addr,
    input  pc, npc, ras_top, ras_valid, redirect, mispredict_cnt
  );

  modport slave (
    input  stall, predict_valid, predict_target, br, br_target, jalr, jalr_target,
           jal, jal_target, link_push, link_pop, link_addr,
    output pc, npc, ras_top, ras_valid, redirect, mispredict_cnt
  );

endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack: push, pop and push+pop swap; oldest entry is
// silently overwritten when full, pops on empty are ignored.
module npc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PTR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [XLEN-1:0]  entry_q [RAS_DEPTH];

  assign top_idx = tp_q - PTR_W'(1);
  assign valid   = (cnt_q != '0);
  assign top     = valid ? entry_q[top_idx] : '0;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (push && pop && valid) begin
      // Coroutine swap: replace the current top in place
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en  = 1'b1;
      tp_d   = tp_q + PTR_W'(1);
      cnt_d  = (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop && valid) begin
      tp_d   = top_idx;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries carry data only and are never reset; cnt_q masks stale contents
  always_ff @(posedge clk) begin
    if (wr_en) entry_q[wr_idx] <= link_addr;
  end

endmodule

// File: rtl/npc_unit.sv
// RV32I fetch PC register with fixed-priority next-PC selection, stall hold,
// return-address stack and a saturating branch-mispredict counter.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int              RAS_DEPTH  = 4,
  parameter int              INST_BYTES = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  npc_unit_if.slave bus
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     mispredict_cnt_q, mispredict_cnt_d;
  logic [XLEN-1:0] npc;
  logic            rd;
  logic            ras_push;
  logic            ras_pop;

  always_comb begin
    npc = pc_q + XLEN'(INST_BYTES);
    if (bus.br)                 npc = bus.br_target;
    else if (bus.jalr)          npc = bus.jalr_target;
    else if (bus.jal)           npc = bus.jal_target;
    else if (bus.stall)         npc = pc_q;
    else if (bus.predict_valid) npc = bus.predict_target;
  end

  always_comb begin
    pc_d             = npc;
    mispredict_cnt_d = bus.br ? sat_inc(mispredict_cnt_q) : mispredict_cnt_q;
  end

  // A mispredicting branch squashes the younger jal/jalr resolving alongside it
  assign rd       = bus.jal | bus.jalr;
  assign ras_push = rd & ~bus.br & bus.link_push;
  assign ras_pop  = rd & ~bus.br & bus.link_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      mispredict_cnt_q <= '0;
    end else begin
      pc_q             <= pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  npc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .link_addr (bus.link_addr),
    .top       (bus.ras_top),
    .valid     (bus.ras_valid)
  );

  assign bus.pc             = pc_q;
  assign bus.npc            = npc;
  assign bus.redirect       = bus.br | bus.jalr | bus.jal;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: driver queues the expected post-edge state,
// monitor compares it against the DUT at the following falling edge.
module tb_npc_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  npc_unit_if #(.XLEN(32)) bus ();

  npc_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .RAS_DEPTH  (4),
    .INST_BYTES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    bit          chk_pc;
    logic        rv;
    logic [31:0] top;
    bit          chk_ras;
    logic [31:0] mc;
    bit          chk_mc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic clear_in();
    bus.stall          = 1'b0;
    bus.predict_valid  = 1'b0;
    bus.predict_target = '0;
    bus.br             = 1'b0;
    bus.br_target      = '0;
    bus.jalr           = 1'b0;
    bus.jalr_target    = '0;
    bus.jal            = 1'b0;
    bus.jal_target     = '0;
    bus.link_push      = 1'b0;
    bus.link_pop       = 1'b0;
    bus.link_addr      = '0;
  endtask

  // Advance one edge and queue the state expected after it
  task automatic cyc(input string nm,
                     input logic [31:0] epc, input bit cpc,
                     input logic ev, input logic [31:0] etop, input bit cras,
                     input logic [31:0] emc, input bit cmc);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm; e.pc = epc; e.chk_pc = cpc;
    e.rv = ev; e.top = etop; e.chk_ras = cras;
    e.mc = emc; e.chk_mc = cmc;
    sb.push_back(e);
  endtask

  task automatic ras_chk(input string nm, input logic ev, input logic [31:0] etop);
    cyc(nm, 32'h0, 1'b0, ev, etop, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic pc_chk(input string nm, input logic [31:0] epc);
    cyc(nm, epc, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ok = 1'b1;
        if (e.chk_pc  && bus.pc !== e.pc)                                   ok = 1'b0;
        if (e.chk_ras && (bus.ras_valid !== e.rv || bus.ras_top !== e.top)) ok = 1'b0;
        if (e.chk_mc  && bus.mispredict_cnt !== e.mc)                       ok = 1'b0;
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got pc=%h ras_valid=%b ras_top=%h mcnt=%0d, want pc=%h ras_valid=%b ras_top=%h mcnt=%0d",
                      e.name, bus.pc, bus.ras_valid, bus.ras_top, bus.mispredict_cnt,
                      e.pc, e.rv, e.top, e.mc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin : driver
    clear_in();
    rst_n = 1'b0;
    cyc("reset", 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'd0, 1'b1);
    rst_n = 1'b1;
    pc_chk("seq1", 32'h4);
    pc_chk("seq2", 32'h8);
    pc_chk("seq3", 32'hC);
    rst_n = 1'b0;
    pc_chk("mid_reset", 32'h0);
    rst_n = 1'b1;

    // Stall holds a predicted target; a redirect overrides stall
    bus.jal = 1'b1; bus.jal_target = 32'h100;
    pc_chk("jal_to_100", 32'h100);
    clear_in();
    bus.predict_valid = 1'b1; bus.predict_target = 32'h200; bus.stall = 1'b1;
    pc_chk("stall_hold", 32'h100);
    bus.stall = 1'b0;
    pc_chk("predict_taken", 32'h200);
    clear_in();
    bus.stall = 1'b1; bus.jal = 1'b1; bus.jal_target = 32'h300;
    pc_chk("jal_over_stall", 32'h300);
    clear_in();

    // Priority: br > jalr > jal > predictor; br squashes the link push
    bus.br = 1'b1;   bus.br_target   = 32'h40;
    bus.jalr = 1'b1; bus.jalr_target = 32'h80;
    bus.jal = 1'b1;  bus.jal_target  = 32'hC0;
    bus.link_push = 1'b1; bus.link_addr = 32'h1234;
    cyc("br_priority", 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 32'd1, 1'b1);
    clear_in();
    bus.jalr = 1'b1; bus.jalr_target = 32'h80;
    bus.jal = 1'b1;  bus.jal_target  = 32'hC0;
    cyc("jalr_priority", 32'h80, 1'b1, 1'b0, 32'h0, 1'b1, 32'd1, 1'b1);
    clear_in();
    bus.jal = 1'b1; bus.jal_target = 32'hC0;
    bus.predict_valid = 1'b1; bus.predict_target = 32'h200;
    pc_chk("jal_over_pred", 32'hC0);
    clear_in();

    // Fill past depth 4: oldest entry overwritten
    bus.jal = 1'b1; bus.jal_target = 32'h1000; bus.link_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.link_addr = 32'h10 * i;
      ras_chk($sformatf("push_%0d", i), 1'b1, 32'h10 * i);
    end
    clear_in();
    bus.jalr = 1'b1; bus.jalr_target = 32'h2000; bus.link_pop = 1'b1;
    ras_chk("pop_1", 1'b1, 32'h40);
    ras_chk("pop_2", 1'b1, 32'h30);
    ras_chk("pop_3", 1'b1, 32'h20);
    ras_chk("pop_4_empty", 1'b0, 32'h0);
    ras_chk("pop_5_underflow", 1'b0, 32'h0);
    clear_in();
    bus.link_push = 1'b1; bus.link_addr = 32'h77;
    ras_chk("push_without_rd", 1'b0, 32'h0);
    clear_in();

    // Swap on non-empty keeps count; swap on empty acts as push
    bus.jal = 1'b1; bus.link_push = 1'b1; bus.link_addr = 32'h10;
    ras_chk("swap_setup", 1'b1, 32'h10);
    clear_in();
    bus.jalr = 1'b1; bus.link_push = 1'b1; bus.link_pop = 1'b1; bus.link_addr = 32'h99;
    ras_chk("swap_nonempty", 1'b1, 32'h99);
    clear_in();
    bus.jalr = 1'b1; bus.link_pop = 1'b1;
    ras_chk("swap_cnt_is_1", 1'b0, 32'h0);
    clear_in();
    bus.jalr = 1'b1; bus.link_push = 1'b1; bus.link_pop = 1'b1; bus.link_addr = 32'hAA;
    ras_chk("swap_empty", 1'b1, 32'hAA);
    clear_in();
    bus.jalr = 1'b1; bus.link_pop = 1'b1;
    ras_chk("swap_empty_cnt_1", 1'b0, 32'h0);
    clear_in();

    // RAS ignores stall; br squashes a pop too
    bus.stall = 1'b1; bus.jal = 1'b1; bus.link_push = 1'b1; bus.link_addr = 32'h55;
    ras_chk("push_under_stall", 1'b1, 32'h55);
    clear_in();
    bus.br = 1'b1; bus.br_target = 32'h500; bus.jalr = 1'b1; bus.link_pop = 1'b1;
    cyc("br_squash_pop", 32'h500, 1'b1, 1'b1, 32'h55, 1'b1, 32'd2, 1'b1);
    clear_in();

    // Sequential wrap at the top of the address space
    bus.jal = 1'b1; bus.jal_target = 32'hFFFF_FFFC;
    pc_chk("to_top", 32'hFFFF_FFFC);
    clear_in();
    pc_chk("wrap", 32'h0000_0000);

    repeat (3) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Parametrised next-PC unit and PC register for the RV32I fetch stage.
- Holds the architectural fetch PC and selects the next PC with fixed priority: branch mispredict, jalr, jal, predictor, sequential.
- Adds stall handling.
- Adds a circular return-address stack (RAS), updated at jal/jalr resolution; its top is exported to the fetch-side predictor.

Parameters:
- XLEN, 32, address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)
- INST_BYTES, 4, sequential increment

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- stall  in  1  hold PC (fetch stall)
- predict_valid  in  1  predictor hit
- predict_target  in  XLEN  predicted target
- br  in  1  branch mispredict redirect
- br_target  in  XLEN  corrected target
- jalr  in  1  jalr resolved
- jalr_target  in  XLEN  jalr target
- jal  in  1  jal resolved
- jal_target  in  XLEN  jal target
- link_push  in  1  resolving jal/jalr writes x1/x5
- link_pop  in  1  resolving jalr reads x1/x5 (return)
- link_addr  in  XLEN  return address of resolving instr (its PC+4)
- pc  out  XLEN  registered fetch PC
- npc  out  XLEN  combinational next PC
- ras_top  out  XLEN  RAS top entry
- ras_valid  out  1  RAS non-empty
- redirect  out  1  br|jalr|jal this cycle
- mispredict_cnt  out  32  saturating count of br redirects

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC; RAS count=0, ptr=0, ras_valid=0; mispredict_cnt=0. Entries need no reset; ras_top is 0 while empty.
- npc selection, combinational:
  - br → br_target
  - else jalr → jalr_target
  - else jal → jal_target
  - else stall → pc
  - else predict_valid → predict_target
  - else pc+INST_BYTES
  - Addition is modulo 2^XLEN: wraps at all-ones.
- pc <= npc every cycle. Redirects override stall: a redirect with stall=1 still loads the target.
- redirect = br|jalr|jal, combinational.
- RAS update uses rd = jal|jalr and the squash rule below:
  - br=1 squashes any jal/jalr in the same cycle (younger instr): no RAS update.
  - link_push/link_pop are ignored unless rd=1 and br=0.
- RAS state: top pointer tp, count cnt (0..RAS_DEPTH).
  - ras_top = entry[tp-1 mod DEPTH] when cnt>0.
  - Push only: write entry[tp]=link_addr; tp=tp+1 (wrap); cnt=min(cnt+1, DEPTH). When full, the oldest entry is overwritten silently.
  - Pop only: if cnt>0, tp=tp-1 (wrap), cnt-1. If empty, no change; no underflow.
  - Push and pop together (coroutine swap):
    - cnt>0: overwrite entry[tp-1] with link_addr; tp and cnt unchanged.
    - cnt=0: acts as a push.
  - RAS updates are not gated by stall.
- mispredict_cnt increments on each cycle with br=1 and saturates at 32'hFFFF_FFFF.
- Latency:
  - pc reflects npc one cycle later.
  - RAS changes are visible on ras_top/ras_valid the cycle after the update.
- Reset asserted mid-operation overrides all inputs the same edge.

Decomposition:
- Shared package holds:
  - XLEN default
  - RESET_PC default
  - the x1/x5 link-register indices, used by the decoder to form link_push/link_pop
- One sub-module: npc_ras (circular stack with push/pop/swap, cnt, tp), parametrised by XLEN and RAS_DEPTH.
- Priority mux and PC register stay in npc_unit.

Test Plan:
- Reset then 3 idle cycles with predict_valid=0 → pc = 0x0, 0x4, 0x8, 0xC; rst_n=0 mid-run → pc=0x0 next edge.
- pc=0x100, predict_valid=1, predict_target=0x200, stall=1 → pc stays 0x100; release stall → pc=0x200. Same with jal=1, jal_target=0x300, stall=1 → pc=0x300.
- br=1 (0x40), jalr=1 (0x80), jal=1 (0xC0) together, link_push=1 → pc=0x40; RAS unchanged; mispredict_cnt=1.
- DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 → ras_top=0x50; pop ×4 gives 0x40, 0x30, 0x20, then ras_valid=0; 5th pop → no change.
- Push 0x10, then push+pop with link_addr=0x99 → ras_top=0x99, cnt=1; push+pop on empty → cnt=1, top=link_addr.
- pc=0xFFFF_FFFC with sequential advance → pc=0x0000_0000.
